// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze geometry, direction encoding, FSM states and bitmap type
package maze_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 60;
    localparam int X_W  = 7;
    localparam int Y_W  = 6;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLACE = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_WIN   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        PLACE = S_PLACE,
        PLAY  = S_PLAY,
        WIN   = S_WIN
    } state_e;

    // level[row][col], 1 = wall; same layout as the loader and renderer
    typedef logic [ROWS-1:0][COLS-1:0] level_t;

endpackage

// File: rtl/player_mover_if.sv
// rtl/player_mover_if.sv - loader/buttons in, player position and status out
interface player_mover_if;
    import maze_pkg::*;

    logic             levelDone;
    level_t           currLevel;
    logic [3:0]       dir;
    logic [X_W-1:0]   playerX;
    logic [Y_W-1:0]   playerY;
    logic             active;
    logic             moved;
    logic             blocked;
    logic             win;

    modport master (
        output levelDone, currLevel, dir,
        input  playerX, playerY, active, moved, blocked, win
    );

    modport slave (
        input  levelDone, currLevel, dir,
        output playerX, playerY, active, moved, blocked, win
    );

endinterface

// File: rtl/move_timer.sv
// rtl/move_timer.sv - held-button rate divider, one tick every MOVE_DIV enabled cycles
module move_timer #(
    parameter int MOVE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(MOVE_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && !clr && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr || !en || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/player_mover.sv
// rtl/player_mover.sv - player cell position, wall/edge collision and win detection
module player_mover
    import maze_pkg::*;
#(
    parameter int COLS     = maze_pkg::COLS,
    parameter int ROWS     = maze_pkg::ROWS,
    parameter int START_X  = 1,
    parameter int START_Y  = 1,
    parameter int GOAL_X   = 78,
    parameter int GOAL_Y   = 58,
    parameter int MOVE_DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    player_mover_if.slave bus
);

    logic [1:0]     state;
    logic           timer_en;
    logic           tick;
    logic           attempt;
    logic           off_grid;
    logic           wall;
    logic           hit_goal;
    logic [X_W-1:0] tx;
    logic [Y_W-1:0] ty;

    assign timer_en = (state == S_PLAY) && (bus.dir != 4'd0);

    move_timer #(.MOVE_DIV(MOVE_DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (timer_en),
        .clr   (bus.levelDone),
        .tick  (tick)
    );

    // Bounds are tested first so the +-1 never wraps; chorded buttons never attempt.
    always_comb begin
        tx       = bus.playerX;
        ty       = bus.playerY;
        off_grid = 1'b0;
        if (bus.dir[DIR_UP]) begin
            off_grid = (bus.playerY == '0);
            if (!off_grid) ty = bus.playerY - Y_W'(1);
        end else if (bus.dir[DIR_DOWN]) begin
            off_grid = (bus.playerY == Y_W'(ROWS - 1));
            if (!off_grid) ty = bus.playerY + Y_W'(1);
        end else if (bus.dir[DIR_LEFT]) begin
            off_grid = (bus.playerX == '0);
            if (!off_grid) tx = bus.playerX - X_W'(1);
        end else if (bus.dir[DIR_RIGHT]) begin
            off_grid = (bus.playerX == X_W'(COLS - 1));
            if (!off_grid) tx = bus.playerX + X_W'(1);
        end
    end

    assign wall     = !off_grid && bus.currLevel[ty][tx];
    assign hit_goal = (tx == X_W'(GOAL_X)) && (ty == Y_W'(GOAL_Y));
    assign attempt  = tick && !bus.levelDone && $onehot(bus.dir);
    assign bus.active = (state == S_PLAY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            bus.playerX <= X_W'(START_X);
            bus.playerY <= Y_W'(START_Y);
            bus.moved   <= 1'b0;
            bus.blocked <= 1'b0;
            bus.win     <= 1'b0;
        end else begin
            bus.moved   <= 1'b0;
            bus.blocked <= 1'b0;
            if (bus.levelDone) begin
                state <= S_PLACE;
            end else begin
                case (state)
                    S_PLACE: begin
                        bus.playerX <= X_W'(START_X);
                        bus.playerY <= Y_W'(START_Y);
                        bus.win     <= 1'b0;
                        state       <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (attempt) begin
                            if (off_grid || wall) begin
                                bus.blocked <= 1'b1;
                            end else begin
                                bus.playerX <= tx;
                                bus.playerY <= ty;
                                bus.moved   <= 1'b1;
                                if (hit_goal) begin
                                    bus.win <= 1'b1;
                                    state   <= S_WIN;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_mover.sv
// tb/tb_player_mover.sv - scoreboard bench for player_mover with directed move sequences
module tb_player_mover;
    import maze_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    player_mover_if bus();

    player_mover #(.MOVE_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit blk;
        int x;
        int y;
        bit w;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  mx = 1;
    int  my = 1;
    bit  mwin = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && (bus.moved || bus.blocked)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got moved=%0b blocked=%0b expected none", bus.moved, bus.blocked);
            end else begin
                mon_e = q.pop_front();
                chk("ev_blocked", int'(bus.blocked), int'(mon_e.blk));
                chk("ev_moved", int'(bus.moved), int'(!mon_e.blk));
                chk("ev_x", int'(bus.playerX), mon_e.x);
                chk("ev_y", int'(bus.playerY), mon_e.y);
                chk("ev_win", int'(bus.win), int'(mon_e.w));
            end
        end
    end

    task automatic attempt(input logic [3:0] d);
        int tx;
        int ty;
        bit off;
        bit exp_ev;
        bus.dir = d;
        exp_ev = 1'b0;
        if ($onehot(d) && !mwin) begin
            tx = mx;
            ty = my;
            off = 1'b0;
            case (d)
                4'b1000: if (my == 0)  off = 1'b1; else ty = my - 1;
                4'b0100: if (my == 59) off = 1'b1; else ty = my + 1;
                4'b0010: if (mx == 0)  off = 1'b1; else tx = mx - 1;
                default: if (mx == 79) off = 1'b1; else tx = mx + 1;
            endcase
            exp_ev = 1'b1;
            if (off || bus.currLevel[ty][tx]) begin
                q.push_back('{1'b1, mx, my, mwin});
            end else begin
                mx = tx;
                my = ty;
                if (mx == 78 && my == 58) mwin = 1'b1;
                q.push_back('{1'b0, mx, my, mwin});
            end
        end
        repeat (4) @(posedge clk);
        #1;
        chk("attempt_timing", int'(bus.moved | bus.blocked), int'(exp_ev));
    endtask

    task automatic release_dir();
        bus.dir = 4'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic place();
        bus.levelDone = 1'b1;
        @(posedge clk);
        #1;
        bus.levelDone = 1'b0;
        chk("place_active", int'(bus.active), 0);
        @(posedge clk);
        #1;
        mx = 1;
        my = 1;
        mwin = 1'b0;
        chk("play_active", int'(bus.active), 1);
        chk("play_x", int'(bus.playerX), 1);
        chk("play_y", int'(bus.playerY), 1);
        chk("play_win", int'(bus.win), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish within 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        bus.levelDone = 1'b0;
        bus.dir       = 4'd0;
        bus.currLevel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", int'(bus.playerX), 1);
        chk("rst_y", int'(bus.playerY), 1);
        chk("rst_active", int'(bus.active), 0);
        chk("rst_win", int'(bus.win), 0);
        chk("rst_moved", int'(bus.moved), 0);
        chk("rst_blocked", int'(bus.blocked), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        bus.dir = 4'b0001;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_x", int'(bus.playerX), 1);
        bus.dir = 4'd0;

        place();
        attempt(4'b0001);
        chk("right1_x", int'(bus.playerX), 2);
        attempt(4'b0001);
        chk("right2_x", int'(bus.playerX), 3);
        release_dir();
        attempt(4'b0001);
        chk("repress_x", int'(bus.playerX), 4);
        release_dir();

        place();
        bus.currLevel[1][2] = 1'b1;
        attempt(4'b0001);
        chk("wall_x", int'(bus.playerX), 1);
        attempt(4'b1001);
        chk("chord_x", int'(bus.playerX), 1);
        release_dir();
        bus.currLevel[1][2] = 1'b0;

        attempt(4'b0010);
        attempt(4'b0010);
        attempt(4'b1000);
        attempt(4'b1000);
        chk("top_y", int'(bus.playerY), 0);
        repeat (5) attempt(4'b0100);
        attempt(4'b0010);
        chk("left_edge_x", int'(bus.playerX), 0);
        chk("left_edge_y", int'(bus.playerY), 5);
        repeat (79) attempt(4'b0001);
        attempt(4'b0001);
        chk("right_edge_x", int'(bus.playerX), 79);
        repeat (2) attempt(4'b0010);
        repeat (53) attempt(4'b0100);
        chk("pre_goal_y", int'(bus.playerY), 58);
        attempt(4'b0001);
        chk("goal_win", int'(bus.win), 1);
        chk("goal_active", int'(bus.active), 0);
        chk("goal_x", int'(bus.playerX), 78);
        attempt(4'b0001);
        attempt(4'b0100);
        chk("frozen_x", int'(bus.playerX), 78);
        chk("frozen_win", int'(bus.win), 1);
        release_dir();
        place();

        attempt(4'b0001);
        chk("pre_rst_x", int'(bus.playerX), 2);
        bus.dir = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_x", int'(bus.playerX), 1);
        chk("async_rst_active", int'(bus.active), 0);
        chk("async_rst_moved", int'(bus.moved), 0);
        bus.dir = 4'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        place();

        bus.dir = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        bus.levelDone = 1'b1;
        @(posedge clk);
        #1;
        bus.levelDone = 1'b0;
        bus.dir = 4'd0;
        chk("coinc_moved", int'(bus.moved), 0);
        chk("coinc_active", int'(bus.active), 0);
        chk("coinc_x", int'(bus.playerX), 1);
        @(posedge clk);
        #1;
        chk("coinc_play", int'(bus.active), 1);
        chk("coinc_play_x", int'(bus.playerX), 1);

        repeat (2) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
